// File: rtl/elm_neuron_driver_if.sv
// Upstream side of the ELM neuron driver: command channel plus ready/valid
// data stream carrying weight, bias and input words.
interface elm_neuron_driver_if #(
  parameter int DATA_WIDTH = 16,
  parameter int CFG_WIDTH  = 33
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_op;
  logic [CFG_WIDTH-1:0]  cmd_layer;
  logic [CFG_WIDTH-1:0]  cmd_neuron;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_valid;
  logic                  s_ready;

  modport master (
    output cmd_valid, cmd_op, cmd_layer, cmd_neuron, s_data, s_valid,
    input  cmd_ready, s_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_layer, cmd_neuron, s_data, s_valid,
    output cmd_ready, s_ready
  );
endinterface

// File: rtl/elm_neuron_driver.sv
// Transmit-side driver for one ELM hidden-layer neuron: streams weights/bias
// or inference inputs to the neuron and returns one activation per INFER.
module elm_neuron_driver #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_WEIGHT = 128,
  parameter int CFG_WIDTH  = 33,
  parameter int OUT_WIDTH  = 16,
  parameter int TIMEOUT    = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  elm_neuron_driver_if.slave    up,
  output logic [CFG_WIDTH-1:0]  config_layer_num,
  output logic [CFG_WIDTH-1:0]  config_neuron_num,
  output logic                  weightValid,
  output logic [DATA_WIDTH-1:0] weightValue,
  output logic                  biasValid,
  output logic [DATA_WIDTH-1:0] biasValue,
  output logic                  myinputValid,
  output logic [DATA_WIDTH-1:0] myinput,
  input  logic [OUT_WIDTH-1:0]  neuron_out,
  input  logic                  neuron_outvalid,
  output logic [OUT_WIDTH-1:0]  result,
  output logic                  result_valid,
  output logic                  busy,
  output logic                  timeout_err
);
  localparam int CNT_W = $clog2(NUM_WEIGHT) + 1;
  localparam int TMO_W = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_WEIGHT - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD_W, S_LOAD_B, S_FEED, S_WAIT} state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic [CFG_WIDTH-1:0]  layer_q, layer_d, neuron_q, neuron_d;
  logic                  wvld_q, wvld_d, bvld_q, bvld_d, ivld_q, ivld_d;
  logic [DATA_WIDTH-1:0] wval_q, wval_d, bval_q, bval_d, ival_q, ival_d;
  logic [OUT_WIDTH-1:0]  res_q, res_d;
  logic                  rvld_q, rvld_d, err_q, err_d;
  logic                  stream_open, cmd_hs, s_hs;

  assign stream_open  = (state_q == S_LOAD_W) || (state_q == S_LOAD_B) || (state_q == S_FEED);
  assign up.cmd_ready = (state_q == S_IDLE);
  assign up.s_ready   = stream_open;
  assign cmd_hs       = up.cmd_valid && (state_q == S_IDLE);
  assign s_hs         = up.s_valid && stream_open;

  always_ff @(posedge clk) begin : state_reg
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin : next_state
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (cmd_hs) state_d = up.cmd_op ? S_FEED : S_LOAD_W;
      S_LOAD_W: if (s_hs && cnt_q == CNT_LAST) state_d = S_LOAD_B;
      S_LOAD_B: if (s_hs) state_d = S_IDLE;
      S_FEED:   if (s_hs && cnt_q == CNT_LAST) state_d = S_WAIT;
      // A response arriving on the last timeout cycle still counts as a result.
      S_WAIT:   if (neuron_outvalid || tmo_q == TMO_LAST) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin : outputs
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
    layer_d  = layer_q;
    neuron_d = neuron_q;
    wvld_d   = 1'b0;
    wval_d   = wval_q;
    bvld_d   = 1'b0;
    bval_d   = bval_q;
    ivld_d   = 1'b0;
    ival_d   = ival_q;
    res_d    = res_q;
    rvld_d   = 1'b0;
    err_d    = err_q;
    case (state_q)
      S_IDLE: if (cmd_hs) begin
        cnt_d = '0;
        if (!up.cmd_op) begin
          layer_d  = up.cmd_layer;
          neuron_d = up.cmd_neuron;
        end
      end
      S_LOAD_W: if (s_hs) begin
        wvld_d = 1'b1;
        wval_d = up.s_data;
        cnt_d  = cnt_q + 1'b1;
      end
      S_LOAD_B: if (s_hs) begin
        bvld_d = 1'b1;
        bval_d = up.s_data;
      end
      S_FEED: if (s_hs) begin
        ivld_d = 1'b1;
        ival_d = up.s_data;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) tmo_d = '0;
      end
      S_WAIT: begin
        if (neuron_outvalid) begin
          res_d  = neuron_out;
          rvld_d = 1'b1;
        end else if (tmo_q == TMO_LAST) begin
          err_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // All-ones config select addresses no neuron after reset.
  always_ff @(posedge clk) begin : data_reg
    if (rst) begin
      cnt_q    <= '0;
      tmo_q    <= '0;
      layer_q  <= '1;
      neuron_q <= '1;
      wvld_q   <= 1'b0;
      wval_q   <= '0;
      bvld_q   <= 1'b0;
      bval_q   <= '0;
      ivld_q   <= 1'b0;
      ival_q   <= '0;
      res_q    <= '0;
      rvld_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      layer_q  <= layer_d;
      neuron_q <= neuron_d;
      wvld_q   <= wvld_d;
      wval_q   <= wval_d;
      bvld_q   <= bvld_d;
      bval_q   <= bval_d;
      ivld_q   <= ivld_d;
      ival_q   <= ival_d;
      res_q    <= res_d;
      rvld_q   <= rvld_d;
      err_q    <= err_d;
    end
  end

  assign config_layer_num  = layer_q;
  assign config_neuron_num = neuron_q;
  assign weightValid       = wvld_q;
  assign weightValue       = wval_q;
  assign biasValid         = bvld_q;
  assign biasValue         = bval_q;
  assign myinputValid      = ivld_q;
  assign myinput           = ival_q;
  assign result            = res_q;
  assign result_valid      = rvld_q;
  assign busy              = (state_q != S_IDLE);
  assign timeout_err       = err_q;
endmodule

// File: tb/tb_elm_neuron_driver.sv
// Randomized directed bench for elm_neuron_driver: every stream word, strobe,
// result and timeout is predicted from the command/stream rules.
module tb_elm_neuron_driver;
  localparam int DW = 16;
  localparam int NW = 128;
  localparam int CW = 33;
  localparam int OW = 16;
  localparam int TO = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [CW-1:0] config_layer_num, config_neuron_num;
  logic          weightValid, biasValid, myinputValid;
  logic [DW-1:0] weightValue, biasValue, myinput;
  logic [OW-1:0] neuron_out = '0;
  logic          neuron_outvalid = 1'b0;
  logic [OW-1:0] result;
  logic          result_valid, busy, timeout_err;

  int checks = 0;
  int failures = 0;

  // Reference state: what the outputs must hold between events.
  logic [CW-1:0] m_layer = '1;
  logic [CW-1:0] m_neuron = '1;
  logic [OW-1:0] m_result = '0;
  bit            m_err = 1'b0;

  elm_neuron_driver_if #(.DATA_WIDTH(DW), .CFG_WIDTH(CW)) bus ();

  elm_neuron_driver #(
    .DATA_WIDTH(DW), .NUM_WEIGHT(NW), .CFG_WIDTH(CW), .OUT_WIDTH(OW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .up(bus),
    .config_layer_num(config_layer_num), .config_neuron_num(config_neuron_num),
    .weightValid(weightValid), .weightValue(weightValue),
    .biasValid(biasValid), .biasValue(biasValue),
    .myinputValid(myinputValid), .myinput(myinput),
    .neuron_out(neuron_out), .neuron_outvalid(neuron_outvalid),
    .result(result), .result_valid(result_valid),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=no_finish required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // dmode: 0 random words, 1 ramp weights then bias 0x0040, 2 constant 0x0100.
  // gap:   0 back-to-back, 1 alternating valid, 2 random valid.
  // resp:  cycles after the last input at which the neuron answers (<1 = silent).
  task automatic run_cmd(input bit op, input logic [CW-1:0] layer, input logic [CW-1:0] neuron,
                         input int gap, input int dmode, input int resp, input logic [OW-1:0] rval,
                         input int abort_at, input bit hold, input bit expect_immediate);
    int waitc, sent, n, iter, done_at;
    bit v, hs, responding;
    logic [DW-1:0] word;
    bus.cmd_valid  = 1'b1;
    bus.cmd_op     = op;
    bus.cmd_layer  = layer;
    bus.cmd_neuron = neuron;
    waitc = 0;
    while (!bus.cmd_ready && waitc < 2000) begin
      tick();
      waitc++;
    end
    if (expect_immediate) chk("accept_latency", 64'(waitc), 0);
    chk("cmd_ready_offer", bus.cmd_ready, 1);
    tick();
    if (!hold) bus.cmd_valid = 1'b0;
    if (!op) begin
      m_layer  = layer;
      m_neuron = neuron;
    end
    chk("busy_accept", busy, 1);
    chk("cmd_ready_accept", bus.cmd_ready, 0);
    chk("cfg_layer", config_layer_num, m_layer);
    chk("cfg_neuron", config_neuron_num, m_neuron);

    n = op ? NW : NW + 1;
    sent = 0;
    iter = 0;
    while (sent < n && iter < 20 * n) begin
      iter++;
      case (gap)
        0:       v = 1'b1;
        1:       v = (iter % 2 == 1);
        default: v = ($urandom_range(2) != 0);
      endcase
      case (dmode)
        1:       word = (sent < NW) ? DW'(sent) : 16'h0040;
        2:       word = 16'h0100;
        default: word = DW'($urandom);
      endcase
      bus.s_valid     = v;
      bus.s_data      = word;
      neuron_outvalid = ($urandom_range(7) == 0);
      neuron_out      = OW'($urandom);
      if (abort_at >= 0 && sent == abort_at) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.s_valid = 1'b0;
        bus.cmd_valid = 1'b0;
        neuron_outvalid = 1'b0;
        m_layer = '1;
        m_neuron = '1;
        m_result = '0;
        m_err = 1'b0;
        chk("abort_weightValid", weightValid, 0);
        chk("abort_cfg_layer", config_layer_num, m_layer);
        chk("abort_cfg_neuron", config_neuron_num, m_neuron);
        chk("abort_busy", busy, 0);
        chk("abort_cmd_ready", bus.cmd_ready, 1);
        chk("abort_s_ready", bus.s_ready, 0);
        return;
      end
      chk("s_ready_stream", bus.s_ready, 1);
      hs = v && bus.s_ready;
      tick();
      chk("weightValid", weightValid, hs && !op && sent < NW);
      if (hs && !op && sent < NW) chk("weightValue", weightValue, word);
      chk("biasValid", biasValid, hs && !op && sent == NW);
      if (hs && !op && sent == NW) chk("biasValue", biasValue, word);
      chk("myinputValid", myinputValid, hs && op);
      if (hs && op) chk("myinput", myinput, word);
      chk("result_valid_stream", result_valid, 0);
      if (hs) sent++;
      chk("cmd_ready_stream", bus.cmd_ready, !op && sent == n);
    end
    if (sent < n) chk("stream_stalled", 64'(sent), 64'(n));
    bus.s_valid = 1'b0;
    neuron_outvalid = 1'b0;

    if (op) begin
      responding = (resp >= 1 && resp <= TO);
      done_at = responding ? resp : TO;
      for (int w = 1; w <= done_at; w++) begin
        neuron_outvalid = (w == resp);
        neuron_out = (w == resp) ? rval : OW'($urandom);
        chk("s_ready_wait", bus.s_ready, 0);
        tick();
        if (w == done_at) begin
          if (responding) m_result = rval;
          else m_err = 1'b1;
        end
        chk("result_valid", result_valid, (w == done_at) && responding);
        chk("busy_wait", busy, w != done_at);
        chk("cmd_ready_wait", bus.cmd_ready, w == done_at);
        chk("timeout_err", timeout_err, m_err);
        chk("result", result, m_result);
      end
      neuron_outvalid = 1'b0;
    end
    chk("idle_busy", busy, 0);
    chk("idle_timeout_err", timeout_err, m_err);
  endtask

  initial begin
    bus.cmd_valid  = 1'b0;
    bus.cmd_op     = 1'b0;
    bus.cmd_layer  = '0;
    bus.cmd_neuron = '0;
    bus.s_valid    = 1'b0;
    bus.s_data     = '0;
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_s_ready", bus.s_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cfg_layer", config_layer_num, {CW{1'b1}});
    chk("rst_cfg_neuron", config_neuron_num, {CW{1'b1}});
    chk("rst_strobes", {weightValid, biasValid, myinputValid, result_valid}, 0);
    chk("rst_data", {weightValue, biasValue, myinput}, 0);
    chk("rst_result", result, 0);
    chk("rst_timeout_err", timeout_err, 0);
    rst = 1'b0;

    // Back-to-back ramp load, then the same load with alternating gaps.
    run_cmd(1'b0, 33'd1, 33'd10, 0, 1, 0, '0, -1, 1'b0, 1'b0);
    run_cmd(1'b0, 33'd1, 33'd10, 1, 1, 0, '0, -1, 1'b0, 1'b0);
    // Inference answered 5 cycles after the last input.
    run_cmd(1'b1, '0, '0, 0, 2, 5, 16'h0ABC, -1, 1'b0, 1'b0);
    // Answer on the very last timeout cycle wins over the timeout.
    run_cmd(1'b1, '0, '0, 2, 0, TO, OW'($urandom), -1, 1'b0, 1'b0);
    // Silent neuron: sticky timeout, then a following INFER still works.
    run_cmd(1'b1, '0, '0, 2, 0, 0, '0, -1, 1'b0, 1'b0);
    run_cmd(1'b1, '0, '0, 2, 0, int'($urandom_range(20, 1)), OW'($urandom), -1, 1'b0, 1'b0);
    // Reset at weight 60, then a fresh load with random gaps and data.
    run_cmd(1'b0, 33'd2, 33'd3, 0, 1, 0, '0, 60, 1'b0, 1'b0);
    run_cmd(1'b0, 33'd1, 33'd10, 2, 0, 0, '0, -1, 1'b0, 1'b0);
    // cmd_valid held through an INFER; the next command goes in at once.
    run_cmd(1'b1, '0, '0, 2, 0, 3, OW'($urandom), -1, 1'b1, 1'b0);
    run_cmd(1'b1, '0, '0, 0, 0, 7, OW'($urandom), -1, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/elm_neuron_driver.md
Name: elm_neuron_driver

Overview:
- Transmit-side driver for one ELM hidden-layer neuron port.
- Sources the neuron's configuration and data streams:
  - weight load: config_layer_num, config_neuron_num, weightValid, weightValue
  - bias load: biasValid, biasValue
  - inference input: myinputValid, myinput
- Consumes the neuron's out/outvalid pair and returns one result per inference command.
- Upstream is the AXI-side command decoder plus a ready/valid data stream; downstream is one neuron instance, or a broadcast bus shared by a layer of neurons.

Parameters:
- DATA_WIDTH, 16, width of weight, bias and input words.
- NUM_WEIGHT, 128, weights and inputs per neuron.
- CFG_WIDTH, 33, width of layer/neuron select (2*DATA_WIDTH+1).
- OUT_WIDTH, 16, width of the neuron activation output.
- TIMEOUT, 1024, maximum cycles to wait for neuron_outvalid.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when both cmd_valid and cmd_ready are high
- cmd_op  in  1  0=LOAD (weights then bias), 1=INFER
- cmd_layer  in  CFG_WIDTH  target layer number for LOAD
- cmd_neuron  in  CFG_WIDTH  target neuron number for LOAD
- s_data  in  DATA_WIDTH  stream word (weight, bias or input)
- s_valid  in  1  stream word valid
- s_ready  out  1  stream word accepted when both s_valid and s_ready are high
- config_layer_num  out  CFG_WIDTH  layer select to neuron
- config_neuron_num  out  CFG_WIDTH  neuron select to neuron
- weightValid  out  1  weight strobe
- weightValue  out  DATA_WIDTH  weight word
- biasValid  out  1  bias strobe
- biasValue  out  DATA_WIDTH  bias word
- myinputValid  out  1  input strobe
- myinput  out  DATA_WIDTH  input word
- neuron_out  in  OUT_WIDTH  neuron activation
- neuron_outvalid  in  1  activation valid, single-cycle pulse
- result  out  OUT_WIDTH  captured activation
- result_valid  out  1  one-cycle pulse with result
- busy  out  1  high in every state except IDLE
- timeout_err  out  1  sticky; set on wait timeout

Behaviour:
- Reset values:
  - FSM in IDLE.
  - All strobes, result_valid, timeout_err and busy = 0.
  - config_layer_num and config_neuron_num = all-ones (matches no neuron).
  - Data outputs, result and counters = 0.
- Registering and latency:
  - All outputs are registered.
  - A stream handshake at cycle N produces the downstream strobe at N+1, carrying the word from cycle N.
- cmd_ready = (state==IDLE). s_ready = 1 only in LOAD_W, LOAD_B and FEED.
- IDLE:
  - On LOAD handshake: latch cmd_layer and cmd_neuron into the config outputs, clear cnt, go to LOAD_W.
  - On INFER handshake: clear cnt, go to FEED.
- LOAD_W:
  - Each stream handshake emits one weightValid pulse with weightValue=s_data and increments cnt.
  - After handshake number NUM_WEIGHT (cnt==NUM_WEIGHT-1 at the handshake), go to LOAD_B.
  - Stream gaps give weightValid=0 that cycle; the neuron tolerates gaps.
- LOAD_B:
  - The next handshake emits a single biasValid pulse with biasValue=s_data, then go to IDLE.
  - Config outputs hold their values until the next LOAD. weightValid is never high in INFER, so held config values are harmless.
  - The neuron's bias capture is not address-qualified, so biasValid reaches every neuron on a shared bus. Software orders LOAD commands accordingly; this block adds no masking.
- FEED:
  - Each handshake emits one myinputValid pulse with myinput=s_data.
  - After handshake number NUM_WEIGHT, go to WAIT, clear tmo.
- WAIT:
  - tmo increments each cycle.
  - On neuron_outvalid: result<=neuron_out, result_valid pulses 1 cycle, go to IDLE.
  - If tmo reaches TIMEOUT-1 without outvalid: set timeout_err and go to IDLE; no result_valid.
  - neuron_outvalid outside WAIT is ignored.
  - If outvalid arrives in the same cycle tmo reaches TIMEOUT-1, outvalid wins and timeout_err stays 0.
- Counters:
  - cnt width is $clog2(NUM_WEIGHT)+1.
  - cnt never wraps within a command; it is cleared on command accept.
- timeout_err clears only on rst.
- Reset mid-operation:
  - Every state returns to IDLE and all strobes deassert the next cycle.
  - A partially loaded neuron is reloaded by reset plus a fresh LOAD; rst also resets the neuron's write pointer.
- A command offered while busy is held off by cmd_ready=0. No command is dropped or queued.

Test Plan:
- LOAD layer=1 neuron=10, weights 0..127 streamed back-to-back, then bias 0x0040 -> 128 weightValid pulses, each one cycle after its handshake, with values 0..127; one biasValid with 0x0040; config outputs =1/10; cmd_ready returns high the cycle after the bias.
- Same LOAD with s_valid toggling 1-0-1 -> exactly 128 weightValid pulses; value order preserved; no strobe in gap cycles.
- INFER with 128 inputs of 0x0100, neuron model asserting outvalid 5 cycles after the last input with out=0x0ABC -> result=0x0ABC, one result_valid pulse, busy falls in the same cycle.
- INFER with the neuron model silent -> timeout_err=1 after TIMEOUT cycles in WAIT; no result_valid; the next INFER is accepted.
- rst asserted at weight 60 of a LOAD -> the next cycle shows weightValid=0, config outputs all-ones, state IDLE; a fresh LOAD completes normally.
- cmd_valid held high during an INFER -> cmd_ready stays 0 until result_valid; the second command is accepted the following cycle.
